// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending controller timer/arbiter blocks.
//   - state_e          : timer scheduler FSM encoding (IDLE=0, RUN=1, DONE=2)
//   - DEF_TICKS_PER_SEC: default clk cycles per second (1 kHz system clock)
//   - DEF_SEC_W        : default width of a seconds count
//   - clog2()          : ceil(log2(value)), never less than 1, used to size
//                        requester IDs and the prescaler
// -----------------------------------------------------------------------------
package vend_pkg;

    localparam int DEF_TICKS_PER_SEC = 1000;
    localparam int DEF_SEC_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Minimum of 1 so a degenerate value still yields a legal vector width.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// -----------------------------------------------------------------------------
// vend_rr_arbiter
// Combinational one-hot round-robin pick. The search starts at ptr_i and wraps
// modulo N; the first asserted request wins.
//   req_i       in  N     request vector
//   ptr_i       in  ID_W  index searched first
//   grant_o     out N     one-hot winner (all zero when no request)
//   grant_idx_o out ID_W  index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module vend_rr_arbiter
    import vend_pkg::*;
#(
    parameter  int N    = 4,
    localparam int ID_W = clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] grant_idx_o
);

    logic            found;
    int              idx;
    logic [ID_W-1:0] sel;

    always_comb begin
        // NOTE: every output and temporary gets a default before the loop, so
        // no path through the block leaves a value held and no latch is inferred.
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            sel = ID_W'(idx);
            if (!found && req_i[sel]) begin
                found        = 1'b1;
                grant_o[sel] = 1'b1;
                grant_idx_o  = sel;
            end
        end
    end

endmodule

// File: rtl/vend_timer_scheduler.sv
// -----------------------------------------------------------------------------
// vend_timer_scheduler
// One seconds-countdown timer shared round-robin among NUM_REQ requesters.
// A grant restarts the prescaler so the first second is always full length;
// on expiry the owner gets a one-cycle done pulse.
//   clk        in  1              system clock (1 kHz)
//   reset_n    in  1              asynchronous, active-low reset
//   req_valid  in  NUM_REQ        per-requester timer request
//   req_secs   in  NUM_REQ*SEC_W  packed durations, slice i for requester i
//   req_ready  out NUM_REQ        one-hot grant, combinational, IDLE only
//   cancel     in  NUM_REQ        per-requester abort (owner, RUN only)
//   done       out NUM_REQ        one-cycle one-hot expiry pulse to owner
//   busy       out 1              timer allocated (RUN or DONE)
//   owner      out ID_W           current owner index, 0 when idle
//   secs_left  out SEC_W          remaining whole seconds, 0 when idle
// -----------------------------------------------------------------------------
module vend_timer_scheduler
    import vend_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter  int SEC_W         = DEF_SEC_W,
    localparam int ID_W          = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*SEC_W-1:0] req_secs,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       cancel,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [ID_W-1:0]          owner,
    output logic [SEC_W-1:0]         secs_left
);

    localparam int              PS_W      = clog2(TICKS_PER_SEC);
    localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(TICKS_PER_SEC - 1);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    state_e                 state_q;
    logic [ID_W-1:0]        rr_ptr_q;
    logic [ID_W-1:0]        rr_ptr_d;
    logic [PS_W-1:0]        presc_q;
    logic [SEC_W-1:0]       secs_left_q;
    logic [ID_W-1:0]        owner_q;
    logic                   busy_q;
    logic [NUM_REQ-1:0]     done_q;

    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        win_idx;
    logic [SEC_W-1:0]       win_secs;

    vend_rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (win_idx)
    );

    assign win_secs = req_secs[win_idx*SEC_W +: SEC_W];
    assign rr_ptr_d = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;

    // No grant is advertised while reset is held, so every output is quiet
    // for the whole reset window.
    assign req_ready = (state_q == ST_IDLE && reset_n) ? grant : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            presc_q     <= '0;
            secs_left_q <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register here samples the pre-edge values of the others.
            done_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        owner_q     <= win_idx;
                        secs_left_q <= win_secs;
                        presc_q     <= PS_RELOAD;
                        rr_ptr_q    <= rr_ptr_d;
                        busy_q      <= 1'b1;
                        if (win_secs == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= grant;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Owner cancel beats a same-cycle expiry.
                    if (cancel[owner_q]) begin
                        state_q     <= ST_IDLE;
                        secs_left_q <= '0;
                        owner_q     <= '0;
                        presc_q     <= '0;
                        busy_q      <= 1'b0;
                    end else if (presc_q == '0) begin
                        presc_q <= PS_RELOAD;
                        // <= 1 rather than == 1 keeps secs_left from wrapping.
                        if (secs_left_q <= SEC_W'(1)) begin
                            state_q     <= ST_DONE;
                            secs_left_q <= '0;
                            done_q      <= NUM_REQ'(1) << owner_q;
                        end else begin
                            secs_left_q <= secs_left_q - 1'b1;
                        end
                    end else begin
                        presc_q <= presc_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    secs_left_q <= '0;
                    owner_q     <= '0;
                    presc_q     <= '0;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign secs_left = secs_left_q;

endmodule

// File: tb/tb_vend_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vend_timer_scheduler
// Directed bench for vend_timer_scheduler with NUM_REQ=4, TICKS_PER_SEC=10,
// SEC_W=8. Single-request jobs come from a table of {requester, seconds,
// done latency}; round robin, cancel and reset corners are hand sequences.
// Cycle numbering: after tick() the bench sits 1 ns past a rising edge, i.e.
// inside the cycle that edge started.
// -----------------------------------------------------------------------------
module tb_vend_timer_scheduler;

    localparam int NR  = 4;
    localparam int TPS = 10;
    localparam int SW  = 8;

    logic             clk;
    logic             reset_n;
    logic [NR-1:0]    req_valid;
    logic [NR*SW-1:0] req_secs;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    cancel;
    logic [NR-1:0]    done;
    logic             busy;
    logic [1:0]       owner;
    logic [SW-1:0]    secs_left;

    vend_timer_scheduler #(
        .NUM_REQ       (NR),
        .TICKS_PER_SEC (TPS),
        .SEC_W         (SW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_secs  (req_secs),
        .req_ready (req_ready),
        .cancel    (cancel),
        .done      (done),
        .busy      (busy),
        .owner     (owner),
        .secs_left (secs_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int    idx;
        int    secs;
        int    lat;   // cycles from grant cycle G to the done cycle
        string name;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (req_ready == '0 && n < 40) begin
            tick();
            n++;
        end
        check({name, " ready seen"}, 32'(|req_ready), 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done == '0 && n < 40) begin
            tick();
            n++;
        end
        check({name, " done seen"}, 32'(|done), 1);
    endtask

    // Watch n cycles; count any done pulse or busy as a failure.
    task automatic watch_quiet(input string name, input int n);
        logic bad = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (done !== '0 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        check({name, " quiet"}, 32'(bad), 0);
    endtask

    // Lone request from idx with the given duration; follows it to done.
    task automatic run_job(input int idx, input int secs, input int lat, input string name);
        int   c;
        logic bad;
        req_secs = '0;
        req_secs[idx*SW +: SW] = SW'(secs);
        req_valid = NR'(1) << idx;
        #1;
        check({name, " grant"}, 32'(req_ready), 32'(NR'(1) << idx));
        tick();
        req_valid = '0;
        c   = 1;
        bad = 1'b0;
        while (done == '0 && c < lat + 20) begin
            if (busy !== 1'b1 || owner !== 2'(idx) ||
                secs_left !== SW'(secs - (c - 1) / TPS)) bad = 1'b1;
            tick();
            c++;
        end
        check({name, " latency"}, 32'(c), 32'(lat));
        check({name, " done idx"}, 32'(done), 32'(NR'(1) << idx));
        check({name, " busy in done"}, 32'(busy), 1);
        check({name, " secs_left in done"}, 32'(secs_left), 0);
        if (secs > 0) check({name, " run track"}, 32'(bad), 0);
        tick();
        check({name, " done cleared"}, 32'(done), 0);
        check({name, " busy cleared"}, 32'(busy), 0);
        check({name, " owner cleared"}, 32'(owner), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    initial begin
        int g_prev;
        vecs[0] = '{idx: 2, secs: 3,   lat: 31,   name: "single r2 s3"};
        vecs[1] = '{idx: 1, secs: 0,   lat: 1,    name: "zero r1"};
        vecs[2] = '{idx: 3, secs: 1,   lat: 11,   name: "single r3 s1"};
        vecs[3] = '{idx: 0, secs: 255, lat: 2551, name: "max r0 s255"};
        vecs[4] = '{idx: 1, secs: 2,   lat: 21,   name: "single r1 s2"};

        reset_n   = 1'b0;
        req_valid = '0;
        req_secs  = '0;
        cancel    = '0;
        tick();
        tick();
        check("reset busy", 32'(busy), 0);
        check("reset owner", 32'(owner), 0);
        check("reset secs_left", 32'(secs_left), 0);
        check("reset done", 32'(done), 0);
        check("reset ready", 32'(req_ready), 0);
        reset_n = 1'b1;
        tick();
        check("idle no req ready", 32'(req_ready), 0);

        for (int v = 0; v < 5; v++) begin
            run_job(vecs[v].idx, vecs[v].secs, vecs[v].lat, vecs[v].name);
            tick();
        end

        // Cancel by owner at G+15, with a non-owner cancel at G+5 first.
        req_secs = '0;
        req_secs[0*SW +: SW] = 8'd5;
        req_valid = 4'b0001;
        #1;
        check("cancel grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        repeat (4) tick();
        cancel = 4'b1000;
        tick();
        cancel = '0;
        check("non-owner cancel busy", 32'(busy), 1);
        check("non-owner cancel secs", 32'(secs_left), 5);
        repeat (9) tick();
        check("pre-cancel secs", 32'(secs_left), 4);
        cancel = 4'b0001;
        tick();
        cancel = '0;
        check("cancel busy", 32'(busy), 0);
        check("cancel secs_left", 32'(secs_left), 0);
        check("cancel owner", 32'(owner), 0);
        watch_quiet("after cancel", 60);

        // Cancel in the exact expiry cycle (G+20 for 2 s) suppresses done.
        req_secs = '0;
        req_secs[0*SW +: SW] = 8'd2;
        req_valid = 4'b0001;
        #1;
        check("expiry cancel grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        repeat (19) tick();
        check("expiry cancel last run secs", 32'(secs_left), 1);
        cancel = 4'b0001;
        tick();
        cancel = '0;
        check("expiry cancel no done", 32'(done), 0);
        check("expiry cancel busy", 32'(busy), 0);
        watch_quiet("after expiry cancel", 30);

        // Cancel in DONE (zero duration) is ignored.
        req_secs = '0;
        req_valid = 4'b0100;
        #1;
        check("done cancel grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        cancel = 4'b0100;
        check("done cancel pulse", 32'(done), 32'h4);
        tick();
        cancel = '0;
        check("done cancel idle", 32'(busy), 0);
        tick();

        // Reset mid-RUN at G+7 with 4 s owned by requester 2.
        req_secs = '0;
        req_secs[2*SW +: SW] = 8'd4;
        req_valid = 4'b0100;
        #1;
        check("reset run grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        repeat (6) tick();
        check("reset run secs before", 32'(secs_left), 4);
        reset_n = 1'b0;
        #1;
        check("async reset busy", 32'(busy), 0);
        check("async reset owner", 32'(owner), 0);
        check("async reset secs_left", 32'(secs_left), 0);
        check("async reset done", 32'(done), 0);
        tick();
        tick();
        reset_n = 1'b1;
        watch_quiet("after reset", 60);

        // Round robin: pointer restarts at 0 after reset; 0,1,2,3,0 spaced 12.
        for (int i = 0; i < NR; i++) req_secs[i*SW +: SW] = 8'd1;
        req_valid = 4'hF;
        #1;
        g_prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ready($sformatf("rr%0d", g));
            check($sformatf("rr%0d grant", g), 32'(req_ready), 32'(NR'(1) << (g % NR)));
            if (g > 0) check($sformatf("rr%0d spacing", g), 32'(cyc - g_prev), 12);
            g_prev = cyc;
            tick();
            wait_done($sformatf("rr%0d", g));
            check($sformatf("rr%0d done idx", g), 32'(done), 32'(NR'(1) << (g % NR)));
            if (g == 4) req_valid = '0;
            tick();
        end
        watch_quiet("after rr", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
